// File: rtl/fifo_sync_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_stream_pkg
// Shared definitions for the synchronous streaming FIFO family: the legal
// depth/width window, the address-width derivation and the storage
// implementation selector used by fifo_sync_mem.
// -----------------------------------------------------------------------------
package fifo_sync_stream_pkg;

  localparam int cMIN_DEPTH = 4;
  localparam int cMAX_DEPTH = 65536;
  localparam int cMIN_WIDTH = 1;
  localparam int cMAX_WIDTH = 256;

  // Storage back-ends; only the RTL array is populated today.
  typedef enum logic {
    MEM_RTL         = 1'b0,
    MEM_XILINX_BRAM = 1'b1
  } memImplE;

  // A depth is legal when it is a power of two inside the supported window.
  function automatic bit isLegalDepth(input int depth);
    return (depth >= cMIN_DEPTH) && (depth <= cMAX_DEPTH) &&
           ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit isLegalWidth(input int width);
    return (width >= cMIN_WIDTH) && (width <= cMAX_WIDTH);
  endfunction

  function automatic int addrWidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// -----------------------------------------------------------------------------
// fifo_sync_mem
// Simple dual-port storage for the sync FIFOs: one synchronous write port and
// one asynchronous read port. Contents are never reset.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module fifo_sync_mem
  import fifo_sync_stream_pkg::*;
#(
  parameter int      pDATA_WIDTH = 8,
  parameter int      pADDR_WIDTH = 5,
  parameter memImplE pIMPL       = MEM_RTL
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [pADDR_WIDTH-1:0] waddr_i,
  input  logic [pDATA_WIDTH-1:0] wdata_i,
  input  logic [pADDR_WIDTH-1:0] raddr_i,
  output logic [pDATA_WIDTH-1:0] rdata_o
);

  if (pIMPL == MEM_RTL) begin : gRtl
    logic [pDATA_WIDTH-1:0] mem_q [0:(2**pADDR_WIDTH)-1];

    // Plain write port; the array is left unreset so it can map to RAM.
    always_ff @(posedge clk) begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end

    assign rdata_o = mem_q[raddr_i];
  end else begin : gBram
    // Hook for a vendor BRAM wrapper; not populated yet.
    $error("fifo_sync_mem: MEM_XILINX_BRAM variant is not available yet");
    assign rdata_o = '0;
  end

endmodule

// File: rtl/fifo_sync_stream.sv
// -----------------------------------------------------------------------------
// fifo_sync_stream
// Single-clock FIFO between sample capture and the readout path. Power-of-two
// depth, exact fill count, programmable almost-full/almost-empty levels,
// synchronous flush, sticky overflow/underflow and a high-watermark.
//
// Ports (W = pADDR_WIDTH):
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous empty-the-FIFO command
//   clear_stats           clears overflow, underflow, max_count
//   wen, wdata            write request and data
//   full                  count == pDEPTH
//   almost_full_thresh    almost-full level (W+1 bits), 0 disables
//   almost_full           count >= almost_full_thresh
//   overflow              sticky: write attempted while full
//   ren, rdata            read request and data
//   empty                 count == 0
//   almost_empty_thresh   almost-empty level (W+1 bits)
//   almost_empty          count <= almost_empty_thresh
//   underflow             sticky: read attempted while empty
//   count                 fill level 0..pDEPTH
//   max_count             peak count since reset or clear_stats
// -----------------------------------------------------------------------------
module fifo_sync_stream
  import fifo_sync_stream_pkg::*;
#(
  parameter int pDATA_WIDTH  = 8,
  parameter int pDEPTH       = 32,
  parameter int pFALLTHROUGH = 0,
  // Derived from pDEPTH; leave at its default.
  parameter int pADDR_WIDTH  = addrWidth(pDEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   clear_stats,
  input  logic                   wen,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   full,
  input  logic [pADDR_WIDTH:0]   almost_full_thresh,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   ren,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   empty,
  input  logic [pADDR_WIDTH:0]   almost_empty_thresh,
  output logic                   almost_empty,
  output logic                   underflow,
  output logic [pADDR_WIDTH:0]   count,
  output logic [pADDR_WIDTH:0]   max_count
);

  if (!isLegalDepth(pDEPTH)) begin : gBadDepth
    $error("fifo_sync_stream: pDEPTH=%0d must be a power of two in 4..65536", pDEPTH);
  end
  if (!isLegalWidth(pDATA_WIDTH)) begin : gBadWidth
    $error("fifo_sync_stream: pDATA_WIDTH=%0d must be in 1..256", pDATA_WIDTH);
  end
  if (pADDR_WIDTH != addrWidth(pDEPTH)) begin : gBadAddr
    $error("fifo_sync_stream: pADDR_WIDTH must not be overridden");
  end

  localparam int PTR_W = pADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] cFULL_COUNT = PTR_W'(pDEPTH);

  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [PTR_W-1:0]       max_count_q, max_count_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic [PTR_W-1:0]       countNow, countNext;
  logic                   fullNow, emptyNow;
  logic                   wrAccept, rdAccept;
  logic [pDATA_WIDTH-1:0] memRdata;

  // Fill level is the modular pointer difference; the extra wrap bit lets
  // full and empty be told apart without any pointer comparison.
  assign countNow = wptr_q - rptr_q;
  assign fullNow  = (countNow == cFULL_COUNT);
  assign emptyNow = (countNow == '0);

  // Accept/reject decisions use the pre-edge full/empty, so a read on a full
  // FIFO still blocks a simultaneous write and vice versa. Flush drops both
  // requests and suppresses the error flags for that cycle.
  always_comb begin
    wrAccept    = wen && !fullNow && !flush;
    rdAccept    = ren && !emptyNow && !flush;
    wptr_d      = wptr_q + PTR_W'(wrAccept);
    rptr_d      = rptr_q + PTR_W'(rdAccept);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
    countNext   = wptr_d - rptr_d;
    overflow_d  = (wen && fullNow && !flush) || (overflow_q && !clear_stats);
    underflow_d = (ren && emptyNow && !flush) || (underflow_q && !clear_stats);
    max_count_d = max_count_q;
    if (clear_stats || (countNext > max_count_q)) begin
      max_count_d = countNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      max_count_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      max_count_q <= max_count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_sync_mem #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pADDR_WIDTH (pADDR_WIDTH),
    .pIMPL       (MEM_RTL)
  ) uMem (
    .clk     (clk),
    .we_i    (wrAccept),
    .waddr_i (wptr_q[pADDR_WIDTH-1:0]),
    .wdata_i (wdata),
    .raddr_i (rptr_q[pADDR_WIDTH-1:0]),
    .rdata_o (memRdata)
  );

  if (pFALLTHROUGH != 0) begin : gFwft
    // Head of the queue is presented directly; meaningless while empty.
    assign rdata = memRdata;
  end else begin : gRegRead
    logic [pDATA_WIDTH-1:0] rdata_q;

    // Registered read holds its value across flushes and idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (rdAccept) begin
        rdata_q <= memRdata;
      end
    end

    assign rdata = rdata_q;
  end

  assign count        = countNow;
  assign full         = fullNow;
  assign empty        = emptyNow;
  assign almost_full  = (almost_full_thresh != '0) && (countNow >= almost_full_thresh);
  assign almost_empty = (countNow <= almost_empty_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign max_count    = max_count_q;

endmodule

// File: tb/tb_fifo_sync_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_stream
// Drives a registered-read and a first-word-fall-through instance (depth 32,
// width 16) with identical directed stimulus and checks both against a
// queue-based model every cycle, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fifo_sync_stream;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          clear_stats = 1'b0;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [CW-1:0] afTh = 6'd28;
  logic [CW-1:0] aeTh = 6'd3;

  logic          fullR, afR, ovfR, emptyR, aeR, unfR;
  logic [DW-1:0] rdataR;
  logic [CW-1:0] countR, maxR;
  logic          fullF, afF, ovfF, emptyF, aeF, unfF;
  logic [DW-1:0] rdataF;
  logic [CW-1:0] countF, maxF;

  int nVectors = 0;
  int nMiscompares = 0;
  bit checkEn = 1'b0;

  // Behavioural model: a plain queue plus the sticky/stat registers.
  logic [DW-1:0] mq [$];
  logic          ovfM, unfM;
  int            maxM;
  logic [DW-1:0] rdRegM;

  always #5 clk = ~clk;

  fifo_sync_stream #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pFALLTHROUGH(0)) dutReg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clear_stats(clear_stats),
    .wen(wen), .wdata(wdata), .full(fullR), .almost_full_thresh(afTh),
    .almost_full(afR), .overflow(ovfR), .ren(ren), .rdata(rdataR),
    .empty(emptyR), .almost_empty_thresh(aeTh), .almost_empty(aeR),
    .underflow(unfR), .count(countR), .max_count(maxR)
  );

  fifo_sync_stream #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pFALLTHROUGH(1)) dutFwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clear_stats(clear_stats),
    .wen(wen), .wdata(wdata), .full(fullF), .almost_full_thresh(afTh),
    .almost_full(afF), .overflow(ovfF), .ren(ren), .rdata(rdataF),
    .empty(emptyF), .almost_empty_thresh(aeTh), .almost_empty(aeF),
    .underflow(unfF), .count(countF), .max_count(maxF)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    ovfM   = 1'b0;
    unfM   = 1'b0;
    maxM   = 0;
    rdRegM = '0;
  endtask

  task automatic modelUpdate(input logic w, input logic [DW-1:0] wd, input logic r,
                             input logic fl, input logic cs);
    logic setO, setU;
    bit   wasFull, wasEmpty;
    setO = 1'b0;
    setU = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      wasFull  = (mq.size() == DEPTH);
      wasEmpty = (mq.size() == 0);
      if (r && !wasEmpty) rdRegM = mq.pop_front();
      if (w && !wasFull) mq.push_back(wd);
      setO = w && wasFull;
      setU = r && wasEmpty;
    end
    ovfM = setO || (ovfM && !cs);
    unfM = setU || (unfM && !cs);
    if (cs || (mq.size() > maxM)) maxM = mq.size();
  endtask

  // One clock of stimulus: drive, let the edge happen, advance the model,
  // and return just after the following falling edge.
  task automatic applyStimulus(input logic w, input logic [DW-1:0] wd, input logic r,
                               input logic fl, input logic cs);
    wen = w; wdata = wd; ren = r; flush = fl; clear_stats = cs;
    @(posedge clk);
    modelUpdate(w, wd, r, fl, cs);
    @(negedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0; clear_stats = 1'b0;
  endtask

  // Model-vs-DUT compare on every falling edge.
  always @(negedge clk) begin
    int   sz;
    logic expFull, expEmpty, expAf, expAe;
    if (checkEn) begin
      sz       = mq.size();
      expFull  = (sz == DEPTH);
      expEmpty = (sz == 0);
      expAf    = (afTh != 0) && (sz >= int'(afTh));
      expAe    = (sz <= int'(aeTh));
      checkOutput("R.count", 32'(countR), sz);
      checkOutput("R.full", 32'(fullR), 32'(expFull));
      checkOutput("R.empty", 32'(emptyR), 32'(expEmpty));
      checkOutput("R.almost_full", 32'(afR), 32'(expAf));
      checkOutput("R.almost_empty", 32'(aeR), 32'(expAe));
      checkOutput("R.overflow", 32'(ovfR), 32'(ovfM));
      checkOutput("R.underflow", 32'(unfR), 32'(unfM));
      checkOutput("R.max_count", 32'(maxR), maxM);
      checkOutput("R.rdata", 32'(rdataR), 32'(rdRegM));
      checkOutput("F.count", 32'(countF), sz);
      checkOutput("F.full", 32'(fullF), 32'(expFull));
      checkOutput("F.empty", 32'(emptyF), 32'(expEmpty));
      checkOutput("F.almost_full", 32'(afF), 32'(expAf));
      checkOutput("F.almost_empty", 32'(aeF), 32'(expAe));
      checkOutput("F.overflow", 32'(ovfF), 32'(ovfM));
      checkOutput("F.underflow", 32'(unfF), 32'(unfM));
      checkOutput("F.max_count", 32'(maxF), maxM);
      if (sz != 0) checkOutput("F.rdata", 32'(rdataF), 32'(mq[0]));
    end
  end

  initial begin
    modelReset();
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("reset.count", 32'(countR), 32'd0);
    checkOutput("reset.empty", 32'(emptyR), 32'd1);
    checkOutput("reset.almost_empty", 32'(aeR), 32'd1);
    checkOutput("reset.full", 32'(fullR), 32'd0);
    checkOutput("reset.almost_full", 32'(afR), 32'd0);
    checkOutput("reset.rdata", 32'(rdataR), 32'd0);
    checkEn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Empty corner: simultaneous read+write on an empty FIFO.
    applyStimulus(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0);
    checkOutput("empty_rw.count", 32'(countR), 32'd1);
    checkOutput("empty_rw.underflow", 32'(unfR), 32'd1);
    checkOutput("empty_rw.fwft_underflow", 32'(unfF), 32'd1);
    checkOutput("empty_rw.fwft_rdata", 32'(rdataF), 32'h0000ABCD);
    checkOutput("empty_rw.reg_rdata", 32'(rdataR), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("clear.underflow", 32'(unfR), 32'd0);
    checkOutput("clear.max_count", 32'(maxR), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("empty_rw.readback", 32'(rdataR), 32'h0000ABCD);

    // Fill to full, then one write too many.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("fill.count", 32'(countR), 32'(i + 1));
      checkOutput("fill.almost_full", 32'(afR), 32'((i + 1) >= 28));
      checkOutput("fill.almost_empty", 32'(aeR), 32'((i + 1) <= 3));
    end
    checkOutput("fill.no_overflow_yet", 32'(ovfR), 32'd0);
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    checkOutput("over.full", 32'(fullR), 32'd1);
    checkOutput("over.count", 32'(countR), 32'd32);
    checkOutput("over.overflow", 32'(ovfR), 32'd1);
    checkOutput("over.max_count", 32'(maxR), 32'd32);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain.fwft_rdata", 32'(rdataF), 32'(i));
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checkOutput("drain.reg_rdata", 32'(rdataR), 32'(i));
    end
    checkOutput("drain.empty", 32'(emptyR), 32'd1);

    // Threshold 0 disables almost_full while filling to 31.
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("clear.overflow", 32'(ovfR), 32'd0);
    afTh = 6'd0;
    for (int k = 0; k < 31; k++) begin
      applyStimulus(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("thresh0.almost_full", 32'(afR), 32'd0);
    afTh = 6'd28;

    // Sustained read+write at count 31 across several pointer wraps.
    for (int n = 0; n < 100; n++) begin
      checkOutput("wrap.fwft_rdata", 32'(rdataF), 32'h100 + 32'(n));
      applyStimulus(1'b1, 16'h0100 + 16'(31 + n), 1'b1, 1'b0, 1'b0);
      checkOutput("wrap.reg_rdata", 32'(rdataR), 32'h100 + 32'(n));
      checkOutput("wrap.count", 32'(countR), 32'd31);
      checkOutput("wrap.full", 32'(fullR), 32'd0);
    end

    // Drain to 20, then flush with both requests active.
    for (int k = 0; k < 11; k++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("preflush.count", 32'(countR), 32'd20);
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
    checkOutput("flush.count", 32'(countR), 32'd0);
    checkOutput("flush.empty", 32'(emptyR), 32'd1);
    checkOutput("flush.overflow", 32'(ovfR), 32'd0);
    checkOutput("flush.underflow", 32'(unfR), 32'd0);
    checkOutput("flush.rdata_held", 32'(rdataR), 32'h0000016E);
    checkOutput("flush.max_count", 32'(maxR), 32'd31);
    applyStimulus(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    checkOutput("postflush.fwft_rdata", 32'(rdataF), 32'h00005A5A);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("postflush.reg_rdata", 32'(rdataR), 32'h00005A5A);

    // Asynchronous reset in the middle of a write burst.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 16'h0200 + 16'(k), 1'b0, 1'b0, 1'b0);
    wen = 1'b1;
    wdata = 16'h02FF;
    @(posedge clk);
    modelUpdate(1'b1, 16'h02FF, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async.count", 32'(countR), 32'd0);
    checkOutput("async.empty", 32'(emptyR), 32'd1);
    checkOutput("async.max_count", 32'(maxR), 32'd0);
    checkOutput("async.rdata", 32'(rdataR), 32'd0);
    checkOutput("async.fwft_count", 32'(countF), 32'd0);
    wen = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h3C3C, 1'b0, 1'b0, 1'b0);
    checkOutput("postreset.count", 32'(countR), 32'd1);
    checkOutput("postreset.fwft_rdata", 32'(rdataF), 32'h00003C3C);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("postreset.reg_rdata", 32'(rdataR), 32'h00003C3C);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
